// File: rtl/eda_regional_max_pkg.sv
// rtl/eda_regional_max_pkg.sv - shared constants, slot offset tables and FSM type for the window evaluator
//
// Purpose: window geometry (WIN slots, raster order over (di,dj) in {-1,0,1}^2,
//          slot 4 is the centre), the corner-slot mask used by the 4-connectivity
//          build, and the evaluator state type.
// Ports:   none (package).
package eda_regional_max_pkg;

  localparam int WIN         = 9;
  localparam int CENTER_SLOT = 4;
  localparam int SLOT_W      = 4;

  // Row / column offsets of slot k = (di+1)*3 + (dj+1).
  localparam int DI [WIN] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int DJ [WIN] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  // Diagonal neighbours, dropped when only 4-connectivity is evaluated.
  localparam logic [WIN-1:0] CORNER_MASK = 9'b101000101;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EVAL,
    RESULT
  } rmax_win_state_t;

endpackage

// File: rtl/eda_regional_max_window_if.sv
// rtl/eda_regional_max_window_if.sv - request, image-RAM read and result bundle of the window evaluator
//
// Purpose: groups the evaluator's request, RAM read port and result handshake.
// Signals: start, center_i, center_j  request (sampled in IDLE)
//          busy                        evaluator not in IDLE
//          rd_en, rd_addr, rd_data     image RAM read, data one cycle after rd_en
//          res_valid, res_ready        result handshake
//          gt_mask, eq_mask, is_max, plateau  result payload
// Modports: master = evaluator side, slave = requester / RAM / result consumer side.
interface eda_regional_max_window_if #(
  parameter int M           = 6,
  parameter int N           = 6,
  parameter int PIXEL_WIDTH = 8,
  parameter int I_WIDTH     = $clog2(M),
  parameter int J_WIDTH     = $clog2(N),
  parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
);

  logic                   start;
  logic [I_WIDTH-1:0]     center_i;
  logic [J_WIDTH-1:0]     center_j;
  logic                   busy;
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [PIXEL_WIDTH-1:0] rd_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [8:0]             gt_mask;
  logic [8:0]             eq_mask;
  logic                   is_max;
  logic                   plateau;

  modport master (
    input  start, center_i, center_j, rd_data, res_ready,
    output busy, rd_en, rd_addr, res_valid, gt_mask, eq_mask, is_max, plateau
  );

  modport slave (
    output start, center_i, center_j, rd_data, res_ready,
    input  busy, rd_en, rd_addr, res_valid, gt_mask, eq_mask, is_max, plateau
  );

endinterface

// File: rtl/eda_window_addr_gen.sv
// rtl/eda_window_addr_gen.sv - combinational (ci,cj,k) to {i,j} address and in-bounds decode
//
// Purpose: maps a window slot to its image address and decides whether the
//          slot is read. Build option EDA_RMAX_CONN8_EN: defined evaluates all
//          8 neighbours; undefined treats corner slots as out-of-bounds.
// Ports:   ci, cj     centre row / column
//          k          slot index 0..8
//          addr       {row, col} of the slot (meaningful only when in_bounds)
//          in_bounds  slot lies inside the image and is enabled by connectivity
module eda_window_addr_gen
  import eda_regional_max_pkg::*;
#(
  parameter int M       = 6,
  parameter int N       = 6,
  parameter int I_WIDTH = $clog2(M),
  parameter int J_WIDTH = $clog2(N)
) (
  input  logic [I_WIDTH-1:0]         ci,
  input  logic [J_WIDTH-1:0]         cj,
  input  logic [SLOT_W-1:0]          k,
  output logic [I_WIDTH+J_WIDTH-1:0] addr,
  output logic                       in_bounds
);

  localparam logic [I_WIDTH-1:0] ROW_LAST = I_WIDTH'(M - 1);
  localparam logic [J_WIDTH-1:0] COL_LAST = J_WIDTH'(N - 1);

  // One extra bit so that centre-1 at the top/left edge goes negative instead of wrapping.
  logic signed [I_WIDTH:0] row;
  logic signed [J_WIDTH:0] col;
  logic                    conn_ok;

`ifdef EDA_RMAX_CONN8_EN
  assign conn_ok = 1'b1;
`else
  assign conn_ok = !CORNER_MASK[k];
`endif

  always_comb begin
    row       = $signed({1'b0, ci}) + $signed((I_WIDTH+1)'(DI[k]));
    col       = $signed({1'b0, cj}) + $signed((J_WIDTH+1)'(DJ[k]));
    // Sign bit set means row/col -1; the magnitude compare catches M / N.
    in_bounds = !row[I_WIDTH] && (row[I_WIDTH-1:0] <= ROW_LAST) &&
                !col[J_WIDTH] && (col[J_WIDTH-1:0] <= COL_LAST) && conn_ok;
    addr      = {row[I_WIDTH-1:0], col[J_WIDTH-1:0]};
  end

endmodule

// File: rtl/eda_regional_max_window.sv
// rtl/eda_regional_max_window.sv - sequential 3x3 neighbourhood evaluator for the regional-max engine
//
// Purpose: on start, reads the centre and its neighbours from the image RAM
//          (one slot per FETCH cycle), compares them against the centre and
//          presents gt/eq masks plus is_max/plateau until accepted.
//          Build option EDA_RMAX_CONN8_EN selects 8-connectivity (default 4).
// Ports:   clk    rising-edge clock
//          reset  synchronous active-high reset
//          clear  synchronous abort to IDLE, drops any pending result
//          bus    eda_regional_max_window_if.master (request, RAM read, result)
module eda_regional_max_window
  import eda_regional_max_pkg::*;
#(
  parameter int M           = 6,
  parameter int N           = 6,
  parameter int PIXEL_WIDTH = 8
) (
  input logic                       clk,
  input logic                       reset,
  input logic                       clear,
  eda_regional_max_window_if.master bus
);

  localparam int I_WIDTH    = $clog2(M);
  localparam int J_WIDTH    = $clog2(N);
  localparam int ADDR_WIDTH = I_WIDTH + J_WIDTH;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIN - 1);

  rmax_win_state_t        state;
  logic [SLOT_W-1:0]      slot;
  logic [I_WIDTH-1:0]     ci_q;
  logic [J_WIDTH-1:0]     cj_q;
  logic [WIN-1:0]         inb_q;
  logic                   cap_en;
  logic [SLOT_W-1:0]      cap_slot;
  logic [PIXEL_WIDTH-1:0] pix [WIN];

  logic [I_WIDTH-1:0]     gen_ci;
  logic [J_WIDTH-1:0]     gen_cj;
  logic [SLOT_W-1:0]      gen_k;
  logic [ADDR_WIDTH-1:0]  gen_addr;
  logic                   gen_inb;
  logic [WIN-1:0]         gt_next;
  logic [WIN-1:0]         eq_next;

  // The read strobe is registered, so the address generator looks one slot
  // ahead: in IDLE it decodes slot 0 from the live request inputs.
  always_comb begin
    gen_ci = ci_q;
    gen_cj = cj_q;
    gen_k  = '0;
    if (state == IDLE) begin
      gen_ci = bus.center_i;
      gen_cj = bus.center_j;
    end else if (state == FETCH && slot != LAST_SLOT) begin
      gen_k = slot + SLOT_W'(1);
    end
  end

  eda_window_addr_gen #(
    .M       (M),
    .N       (N),
    .I_WIDTH (I_WIDTH),
    .J_WIDTH (J_WIDTH)
  ) u_addr_gen (
    .ci        (gen_ci),
    .cj        (gen_cj),
    .k         (gen_k),
    .addr      (gen_addr),
    .in_bounds (gen_inb)
  );

  // Slots never read keep stale pixels; inb_q masks them out of the compare.
  always_comb begin
    gt_next = '0;
    eq_next = '0;
    for (int k = 0; k < WIN; k++) begin
      if (k != CENTER_SLOT && inb_q[k]) begin
        gt_next[k] = pix[k] > pix[CENTER_SLOT];
        eq_next[k] = pix[k] == pix[CENTER_SLOT];
      end
    end
  end

  always_ff @(posedge clk) begin
    // clear has the same effect as reset, so a single branch serves both.
    if (reset || clear) begin
      state         <= IDLE;
      slot          <= '0;
      ci_q          <= '0;
      cj_q          <= '0;
      inb_q         <= '0;
      cap_en        <= 1'b0;
      cap_slot      <= '0;
      bus.busy      <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.res_valid <= 1'b0;
      bus.gt_mask   <= '0;
      bus.eq_mask   <= '0;
      bus.is_max    <= 1'b0;
      bus.plateau   <= 1'b0;
    end else begin
      // RAM data returns one cycle after the strobe; remember which slot it belongs to.
      cap_en   <= bus.rd_en;
      cap_slot <= slot;
      if (cap_en) begin
        pix[cap_slot] <= bus.rd_data;
      end

      case (state)
        IDLE: begin
          bus.rd_en <= 1'b0;
          if (bus.start) begin
            ci_q        <= bus.center_i;
            cj_q        <= bus.center_j;
            slot        <= '0;
            inb_q[0]    <= gen_inb;
            bus.rd_en   <= gen_inb;
            bus.rd_addr <= gen_addr;
            bus.busy    <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (slot == LAST_SLOT) begin
            bus.rd_en <= 1'b0;
            state     <= WAIT;
          end else begin
            slot         <= gen_k;
            inb_q[gen_k] <= gen_inb;
            bus.rd_en    <= gen_inb;
            bus.rd_addr  <= gen_addr;
          end
        end
        WAIT: begin
          state <= EVAL;
        end
        EVAL: begin
          bus.gt_mask   <= gt_next;
          bus.eq_mask   <= eq_next;
          bus.is_max    <= (gt_next == '0);
          bus.plateau   <= (gt_next == '0) && (eq_next != '0);
          bus.res_valid <= 1'b1;
          state         <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eda_regional_max_window.sv
// tb/tb_eda_regional_max_window.sv - directed self-checking bench for eda_regional_max_window
module tb_eda_regional_max_window;

`ifdef EDA_RMAX_CONN8_EN
  localparam bit CONN8 = 1'b1;
`else
  localparam bit CONN8 = 1'b0;
`endif

  // Every neighbour equal to the centre, per connectivity build.
  localparam logic [8:0] EQ_ALL = CONN8 ? 9'b111101111 : 9'b010101010;

  logic clk;
  logic reset;
  logic clear;

  eda_regional_max_window_if bus ();

  eda_regional_max_window dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 6x6 image RAM ({i,j} addressing), 1-cycle read latency, with a read log.
  logic [7:0]  mem [64];
  logic        clr_log;
  logic [63:0] read_map;
  int          rd_count;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (clr_log) begin
      read_map <= '0;
      rd_count <= 0;
    end else if (bus.rd_en) begin
      read_map[bus.rd_addr] <= 1'b1;
      rd_count <= rd_count + 1;
    end
  end

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int i, input int j);
    return i * 8 + j;
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int a = 0; a < 64; a++) mem[a] = v;
  endtask

  // Start at edge 0, then count edges until res_valid; the window must answer at edge 11.
  task automatic run_eval(input int ci, input int cj);
    int lat;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.center_i = 3'(ci);
    bus.center_j = 3'(cj);
    clr_log      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    clr_log   = 1'b0;
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 11);
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("accept_busy", bus.busy, 0);
    check("accept_valid", bus.res_valid, 0);
  endtask

  initial begin
    int seen;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    clear         = 1'b0;
    bus.start     = 1'b0;
    bus.center_i  = '0;
    bus.center_j  = '0;
    bus.res_ready = 1'b0;
    clr_log       = 1'b1;
    fill(8'h00);
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    clr_log = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_gt", bus.gt_mask, 0);
    check("rst_eq", bus.eq_mask, 0);
    check("rst_is_max", bus.is_max, 0);
    check("rst_plateau", bus.plateau, 0);

    // 1: strict maximum in the interior.
    fill(8'h10);
    mem[idx(2, 2)] = 8'h50;
    run_eval(2, 2);
    check("t1_gt", bus.gt_mask, 0);
    check("t1_eq", bus.eq_mask, 0);
    check("t1_is_max", bus.is_max, 1);
    check("t1_plateau", bus.plateau, 0);
    check("t1_reads", rd_count, CONN8 ? 9 : 5);
    accept();

    // 2: top-left corner plateau with its right neighbour.
    fill(8'h10);
    mem[idx(0, 0)] = 8'h20;
    mem[idx(0, 1)] = 8'h20;
    run_eval(0, 0);
    check("t2_gt", bus.gt_mask, 0);
    check("t2_eq", bus.eq_mask, 9'b000100000);
    check("t2_is_max", bus.is_max, 1);
    check("t2_plateau", bus.plateau, 1);
    check("t2_reads", rd_count, CONN8 ? 4 : 3);
    accept();

    // 3: bottom-right corner, larger diagonal neighbour.
    fill(8'h01);
    mem[idx(5, 5)] = 8'h05;
    mem[idx(4, 4)] = 8'h09;
    run_eval(5, 5);
    check("t3_gt", bus.gt_mask, CONN8 ? 9'h001 : 9'h000);
    check("t3_eq", bus.eq_mask, 0);
    check("t3_is_max", bus.is_max, CONN8 ? 0 : 1);
    check("t3_plateau", bus.plateau, 0);
    check("t3_diag_read", read_map[idx(4, 4)], CONN8 ? 1 : 0);
    check("t3_reads", rd_count, CONN8 ? 4 : 3);
    accept();

    // 4: back-pressure with start pulses, start also high in the accept cycle.
    fill(8'h30);
    run_eval(3, 3);
    for (int c = 0; c < 5; c++) begin
      bus.start    = c[0];
      bus.center_i = 3'd1;
      bus.center_j = 3'd1;
      @(posedge clk);
      #1;
      check("t4_hold_valid", bus.res_valid, 1);
      check("t4_hold_eq", bus.eq_mask, EQ_ALL);
      check("t4_hold_plateau", bus.plateau, 1);
    end
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    check("t4_acc_busy", bus.busy, 0);
    check("t4_acc_valid", bus.res_valid, 0);
    @(posedge clk);
    #1;
    check("t4_start_ignored", bus.busy, 0);

    // 5: clear during FETCH slot 4, then a fresh evaluation.
    fill(8'h10);
    mem[idx(2, 2)] = 8'h50;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.center_i = 3'd2;
    bus.center_j = 3'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_slot4_rd_en", bus.rd_en, 1);
    check("t5_slot4_addr", bus.rd_addr, idx(2, 2));
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("t5_clr_busy", bus.busy, 0);
    check("t5_clr_rd_en", bus.rd_en, 0);
    check("t5_clr_valid", bus.res_valid, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.res_valid === 1'b1) seen++;
    end
    check("t5_no_valid", seen, 0);
    run_eval(2, 2);
    check("t5_gt", bus.gt_mask, 0);
    check("t5_is_max", bus.is_max, 1);
    accept();

    // 6: reset in RESULT, then saturated plateau.
    fill(8'h10);
    mem[idx(2, 2)] = 8'h50;
    run_eval(2, 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_valid", bus.res_valid, 0);
    check("t6_rst_is_max", bus.is_max, 0);
    check("t6_rst_gt", bus.gt_mask, 0);
    check("t6_rst_rd_en", bus.rd_en, 0);
    fill(8'hFF);
    run_eval(1, 1);
    check("t6_gt", bus.gt_mask, 0);
    check("t6_eq", bus.eq_mask, EQ_ALL);
    check("t6_is_max", bus.is_max, 1);
    check("t6_plateau", bus.plateau, 1);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
